rgb_axis_packer: RTL
====================

Name: rgb_axis_packer

Overview:
- Downstream neighbour of the pixel generator's colour stage; sits between the generator's r/g/b outputs and the VDMA AXI4-Stream input.
- Accepts one 24-bit pixel per handshake and packs 4 pixels into 3 32-bit words as a dense byte stream.
- Marks start-of-frame on tuser and end-of-line on tlast.
- Buffers output words in a small FIFO so the upstream ready never depends combinationally on out_stream_tready.

Parameters:
- FIFO_DEPTH, 4, output word FIFO entries; power of two, minimum 4.
- LINE_PIXELS, 640, expected pixels per line; used only with RGB_PACKER_LINE_CHECK_EN.

Ports:
- aclk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- r  in  8  pixel red.
- g  in  8  pixel green.
- b  in  8  pixel blue.
- valid_int  in  1  pixel valid.
- sof  in  1  pixel is first of frame; qualified by valid_int.
- eol  in  1  pixel is last of line; qualified by valid_int.
- in_stream_ready  out  1  packer can accept a pixel this cycle.
- out_stream_tdata  out  32  packed bytes.
- out_stream_tkeep  out  4  byte enables.
- out_stream_tlast  out  1  last word of line.
- out_stream_tuser  out  1  first word of frame.
- out_stream_tvalid  out  1  word valid.
- out_stream_tready  in  1  sink ready.
- line_err  out  1  sticky line-length error; present only with RGB_PACKER_LINE_CHECK_EN.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied, phase=0, residual bytes discarded.
  - All outputs 0, including in_stream_ready and tkeep; line_err also 0.
  - in_stream_ready goes 1 on the first cycle after reset is low.
  - Reset mid-frame drops all buffered data; no partial word is emitted.
- Pixel accept:
  - A pixel is accepted when valid_int && in_stream_ready.
  - in_stream_ready = (FIFO occupancy <= FIFO_DEPTH-2), computed from registered state only.
- Pixel byte order: b, g, r, each packed in turn into the next free byte position, lowest byte first.
- Phase counter 0..3 advances on each accept:
  - ph0: store 3 bytes; no word.
  - ph1: push word {p1.b, p0.r, p0.g, p0.b}; keep 2 residual bytes.
  - ph2: push word {p2.g, p2.b, p1.r, p1.g}; keep 1 residual byte.
  - ph3: push word {p3.r, p3.g, p3.b, p2.r}; phase returns to 0.
- FIFO word fields and tkeep:
  - Each FIFO entry holds data[31:0], keep[3:0], last, user.
  - Full words use keep=4'hF.
- eol handling:
  - Any bytes still residual after the eol pixel are flushed as an extra word in the same cycle.
  - The flush word is zero-padded in the upper bytes; keep marks only the valid low bytes: 3 bytes=4'h7, 2 bytes=4'h3, 1 byte=4'h1.
  - last=1 on the final word produced by the eol pixel; phase resets to 0.
  - One accept therefore pushes at most 2 words, which the ready rule guarantees space for.
- sof handling:
  - user=1 on the first word containing any byte of the sof pixel.
  - If sof arrives with phase!=0, residual bytes are discarded and phase restarts at 0 before the pixel is packed.
- Output timing and handshake:
  - FIFO output is registered. A word is visible on out_stream_* the cycle after the accepting edge when the FIFO was empty.
  - Full throughput is 1 pixel/cycle when tready is held high.
  - Once tvalid=1, tdata/tkeep/tlast/tuser stay stable until tready=1.
  - A push and a pop in the same cycle are both honoured; occupancy changes by pushes minus pops.
- Empty FIFO: tvalid=0 and the other stream outputs hold their last values.

Optional Feature:
- Macro: RGB_PACKER_LINE_CHECK_EN.
- With it defined:
  - A 10-bit pixel counter counts accepts and resets on the eol pixel.
  - line_err is set and held until reset if an eol pixel is not pixel LINE_PIXELS, if the count reaches LINE_PIXELS without eol, or if sof arrives with phase!=0.
  - Data behaviour is unchanged.
- Without it: the line_err port, the counter and the checking logic are absent.

Test Plan:
- Reset held 3 cycles, then released:
  - During reset: all outputs 0.
  - First cycle after release: in_stream_ready=1, tvalid=0.
- Four pixels (r,g,b) = (01,02,03), (04,05,06), (07,08,09), (0A,0B,0C), sof on the first, tready=1 → three words, tkeep=F on each:
  - 0x06010203 with tuser=1.
  - 0x08090405.
  - 0x0A0B0C07.
- Full 640-pixel line ending with eol → exactly 480 words; only word 480 has tlast=1; no padding word.
- Single pixel (11,22,33) with sof and eol → one word, 0x00112233, tkeep=4'h7, tlast=1, tuser=1.
- Backpressure, tready=0 for 10 cycles during continuous valid_int:
  - in_stream_ready drops once occupancy exceeds FIFO_DEPTH-2.
  - The stalled word stays stable.
  - After release: no word lost or duplicated, and the byte order matches the reference packing.
- Reset asserted mid-line after 2 pixels, then a new sof line → the first word carries tuser=1 and no bytes from before reset.
- With RGB_PACKER_LINE_CHECK_EN:
  - eol on pixel 639 → line_err=1 and stays 1.
  - A correct 640-pixel line from reset → line_err=0.

Source files
------------

// File: rtl/rgb_axis_packer.sv
// rgb_axis_packer: packs 24-bit b/g/r pixels into a dense 32-bit AXI4-Stream
// byte stream (4 pixels -> 3 words), with tuser on frame start, tlast on eol.
//
// Ports:
//   aclk, reset          clock; synchronous active-high reset
//   r, g, b, valid_int   pixel input (accepted on valid_int && in_stream_ready)
//   sof, eol             frame start / line end, qualified by valid_int
//   in_stream_ready      registered ready, depends only on FIFO occupancy
//   out_stream_*         AXI4-Stream master (tdata/tkeep/tlast/tuser/tvalid/tready)
//   line_err             sticky line-length error (RGB_PACKER_LINE_CHECK_EN only)
//
// Optional macro RGB_PACKER_LINE_CHECK_EN adds the line_err port and checker.
module rgb_axis_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int LINE_PIXELS = 640
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid_int,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready
`ifdef RGB_PACKER_LINE_CHECK_EN
    ,
    output logic        line_err
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] READY_MAX = (CW+1)'(FIFO_DEPTH - 2);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 4");
    end
    if (LINE_PIXELS < 1 || LINE_PIXELS > 1023) begin : g_bad_line
        $error("LINE_PIXELS must fit the 10-bit pixel counter");
    end

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } word_t;

    word_t         mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] mem_cnt;
    word_t         out_q;
    logic          out_valid_q;
    logic          ready_q;
    logic [1:0]    phase_q;
    logic [23:0]   resid_q;
    logic          user_pend_q;

    logic          accept;
    logic [1:0]    ph;
    logic          ufirst;
    logic [1:0]    n_push;
    word_t         pw0;
    word_t         pw1;
    logic [1:0]    phase_d;
    logic [23:0]   resid_d;
    logic          pend_d;

    assign accept = valid_int & ready_q;
    // A sof pixel discards any residual bytes and restarts packing at phase 0.
    assign ph     = sof ? 2'd0 : phase_q;
    assign ufirst = sof | user_pend_q;

    always_comb begin
        n_push  = 2'd0;
        pw0     = '0;
        pw1     = '0;
        phase_d = phase_q;
        resid_d = resid_q;
        pend_d  = user_pend_q;
        if (accept) begin
            case (ph)
                2'd0: begin
                    resid_d = {r, g, b};
                    phase_d = 2'd1;
                    if (eol) begin
                        n_push   = 2'd1;
                        pw0.data = {8'h00, r, g, b};
                        pw0.keep = 4'h7;
                        pw0.last = 1'b1;
                        pw0.user = ufirst;
                    end
                end
                2'd1: begin
                    n_push   = 2'd1;
                    pw0.data = {b, resid_q};
                    pw0.keep = 4'hF;
                    pw0.user = ufirst;
                    resid_d  = {8'h00, r, g};
                    phase_d  = 2'd2;
                    if (eol) begin
                        n_push   = 2'd2;
                        pw1.data = {16'h0000, r, g};
                        pw1.keep = 4'h3;
                        pw1.last = 1'b1;
                    end
                end
                2'd2: begin
                    n_push   = 2'd1;
                    pw0.data = {g, b, resid_q[15:0]};
                    pw0.keep = 4'hF;
                    pw0.user = ufirst;
                    resid_d  = {16'h0000, r};
                    phase_d  = 2'd3;
                    if (eol) begin
                        n_push   = 2'd2;
                        pw1.data = {24'h000000, r};
                        pw1.keep = 4'h1;
                        pw1.last = 1'b1;
                    end
                end
                default: begin
                    n_push   = 2'd1;
                    pw0.data = {r, g, b, resid_q[7:0]};
                    pw0.keep = 4'hF;
                    pw0.last = eol;
                    pw0.user = ufirst;
                    phase_d  = 2'd0;
                end
            endcase
            if (eol) begin
                phase_d = 2'd0;
            end
            // tuser stays pending until a word actually carries sof bytes.
            pend_d = (n_push == 2'd0) ? ufirst : 1'b0;
        end
    end

    // out_q is the registered head of the FIFO; mem holds the words behind it.
    logic          free;
    logic          mem_pop;
    logic [1:0]    mp_n;
    word_t         mw0;
    word_t         mw1;
    word_t         out_d;
    logic          outv_d;
    logic [CW-1:0] mem_cnt_d;
    logic [CW:0]   occ_d;

    assign free = ~out_valid_q | out_stream_tready;

    always_comb begin
        out_d   = out_q;
        outv_d  = out_valid_q & ~out_stream_tready;
        mem_pop = 1'b0;
        mp_n    = n_push;
        mw0     = pw0;
        mw1     = pw1;
        if (free) begin
            if (mem_cnt != '0) begin
                out_d   = mem[rd_ptr];
                outv_d  = 1'b1;
                mem_pop = 1'b1;
            end else if (n_push != 2'd0) begin
                // Empty FIFO: first new word bypasses straight to the output.
                out_d  = pw0;
                outv_d = 1'b1;
                mp_n   = n_push - 2'd1;
                mw0    = pw1;
            end
        end
        mem_cnt_d = mem_cnt + CW'(mp_n) - CW'(mem_pop);
        occ_d     = {1'b0, mem_cnt_d} + (CW+1)'(outv_d);
    end

    always_ff @(posedge aclk) begin
        if (mp_n != 2'd0) begin
            mem[wr_ptr] <= mw0;
        end
        if (mp_n == 2'd2) begin
            mem[wr_ptr + AW'(1)] <= mw1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            mem_cnt     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            phase_q     <= 2'd0;
            resid_q     <= '0;
            user_pend_q <= 1'b0;
        end else begin
            rd_ptr      <= rd_ptr + AW'(mem_pop);
            wr_ptr      <= wr_ptr + AW'(mp_n);
            mem_cnt     <= mem_cnt_d;
            out_q       <= out_d;
            out_valid_q <= outv_d;
            ready_q     <= (occ_d <= READY_MAX);
            phase_q     <= phase_d;
            resid_q     <= resid_d;
            user_pend_q <= pend_d;
        end
    end

    assign in_stream_ready   = ready_q;
    assign out_stream_tdata  = out_q.data;
    assign out_stream_tkeep  = out_q.keep;
    assign out_stream_tlast  = out_q.last;
    assign out_stream_tuser  = out_q.user;
    assign out_stream_tvalid = out_valid_q;

`ifdef RGB_PACKER_LINE_CHECK_EN
    localparam logic [9:0] LP = 10'(LINE_PIXELS);

    logic [9:0] pix_cnt;
    logic [9:0] pix_inc;
    logic       err_q;

    assign pix_inc = pix_cnt + 10'd1;

    always_ff @(posedge aclk) begin
        if (reset) begin
            pix_cnt <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            if (sof && phase_q != 2'd0) begin
                err_q <= 1'b1;
            end
            if (eol) begin
                pix_cnt <= '0;
                if (pix_inc != LP) begin
                    err_q <= 1'b1;
                end
            end else begin
                pix_cnt <= pix_inc;
                if (pix_inc == LP) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign line_err = err_q;
`endif

endmodule
